// File: rtl/aes_pkg.sv
// Shared AES round-key store definitions: key geometry and the store's state enum.
package aes_pkg;

  localparam int unsigned AES_NR        = 10;
  localparam int unsigned AES_KEY_BYTES = 16;
  localparam int unsigned RKEY_DEPTH    = (AES_NR + 1) * AES_KEY_BYTES;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_FULL    = 2'd1,
    ST_PLAY    = 2'd2
  } rkey_state_e;

endpackage

// File: rtl/aes_rkey_ram.sv
// Round-key storage: 8-bit wide, one write port, one registered read port.
// Contents are not reset; every location is rewritten before it is read.
module aes_rkey_ram
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH = RKEY_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read port, read every cycle
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/aes_rkey_store.sv
// AES round-key store: captures the key-expansion byte stream and plays it
// back round by round, descending for decryption. Defining RKEY_FWD_PLAY_EN
// adds a fwd input that selects ascending playback for encryption.
module aes_rkey_store
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS    = AES_NR,
  parameter int unsigned BYTES_PER_KEY = AES_KEY_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       wr_valid,
  input  logic [7:0] wr_byte,
  output logic       wr_ready,
  output logic       keys_ready,
  input  logic       start_dec,
  output logic       rk_valid,
  output logic [7:0] rk_byte,
  input  logic       rk_ready,
`ifdef RKEY_FWD_PLAY_EN
  input  logic       fwd,
`endif
  output logic [3:0] rk_round,
  output logic       rk_last
);

  localparam int unsigned DEPTH = (NUM_ROUNDS + 1) * BYTES_PER_KEY;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BW    = (BYTES_PER_KEY > 1) ? $clog2(BYTES_PER_KEY) : 1;

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(BYTES_PER_KEY - 1);
  localparam logic [3:0]    LAST_ROUND = 4'(NUM_ROUNDS);

  rkey_state_e   state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]    round_q, round_d;
  logic [BW-1:0] byte_q, byte_d;
  logic          dir_q, dir_d;   // 1 = ascending rounds
  logic          start_fwd;
  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

`ifdef RKEY_FWD_PLAY_EN
  assign start_fwd = fwd;
`else
  assign start_fwd = 1'b0;
`endif

  // State, write pointer and play counters; rst overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CAPTURE;
      wr_ptr_q <= '0;
      round_q  <= '0;
      byte_q   <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      round_q  <= round_d;
      byte_q   <= byte_d;
      dir_q    <= dir_d;
    end
  end

  // Next-state, write enable and read address; load beats all other inputs
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    round_d  = round_q;
    byte_d   = byte_q;
    dir_d    = dir_q;
    wr_en    = 1'b0;
    if (load) begin
      state_d  = ST_CAPTURE;
      wr_ptr_d = '0;
      round_d  = '0;
      byte_d   = '0;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          if (wr_valid) begin
            wr_en = 1'b1;
            if (wr_ptr_q == LAST_ADDR) begin
              state_d  = ST_FULL;
              wr_ptr_d = '0;
            end else begin
              wr_ptr_d = wr_ptr_q + AW'(1);
            end
          end
        end
        ST_FULL: begin
          if (start_dec) begin
            state_d = ST_PLAY;
            dir_d   = start_fwd;
            byte_d  = '0;
            round_d = start_fwd ? 4'd0 : LAST_ROUND;
          end
        end
        ST_PLAY: begin
          if (rk_ready) begin
            if (byte_q == LAST_BYTE) begin
              byte_d = '0;
              if (round_q == (dir_q ? LAST_ROUND : 4'd0)) begin
                state_d = ST_FULL;
              end else if (dir_q) begin
                round_d = round_q + 4'd1;
              end else begin
                round_d = round_q - 4'd1;
              end
            end else begin
              byte_d = byte_q + BW'(1);
            end
          end
        end
        default: state_d = ST_CAPTURE;
      endcase
    end
    // Address the RAM with the next play position so the registered read
    // lands on the byte presented in the following cycle; during a stall
    // the same address is re-read and the output holds.
    rd_addr = AW'(round_d) * AW'(BYTES_PER_KEY) + AW'(byte_d);
  end

  aes_rkey_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_byte),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign wr_ready   = (state_q == ST_CAPTURE);
  assign keys_ready = (state_q == ST_FULL) || (state_q == ST_PLAY);
  assign rk_valid   = (state_q == ST_PLAY);
  assign rk_byte    = rk_valid ? rd_data : 8'h00;
  assign rk_round   = round_q;
  assign rk_last    = rk_valid && (byte_q == LAST_BYTE);

endmodule

// File: tb/tb_aes_rkey_store.sv
// Bench for aes_rkey_store: expands AES-128 keys in a behavioural model,
// streams the round keys in and checks playback order, flow control,
// load/reset aborts and ignored controls.
module tb_aes_rkey_store;

  logic       clk;
  logic       rst;
  logic       load;
  logic       wr_valid;
  logic [7:0] wr_byte;
  logic       wr_ready;
  logic       keys_ready;
  logic       start_dec;
  logic       rk_valid;
  logic [7:0] rk_byte;
  logic       rk_ready;
`ifdef RKEY_FWD_PLAY_EN
  logic       fwd;
`endif
  logic [3:0] rk_round;
  logic       rk_last;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl [176];
  logic [7:0] got [176];

  aes_rkey_store #(
    .NUM_ROUNDS    (10),
    .BYTES_PER_KEY (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .wr_valid   (wr_valid),
    .wr_byte    (wr_byte),
    .wr_ready   (wr_ready),
    .keys_ready (keys_ready),
    .start_dec  (start_dec),
    .rk_valid   (rk_valid),
    .rk_byte    (rk_byte),
    .rk_ready   (rk_ready),
`ifdef RKEY_FWD_PLAY_EN
    .fwd        (fwd),
`endif
    .rk_round   (rk_round),
    .rk_last    (rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- AES-128 key expansion model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 176; k++) begin
      t = w[k/4];
      mdl[k] = t[31 - 8*(k%4) -: 8];
    end
  endtask

  // ---------------- stimulus tasks ----------------
  // Stream the 176 model bytes; gaps inserts idle cycles, start_dec is
  // pulsed together with byte sd_at (which must be ignored).
  task automatic capture(input bit gaps, input int sd_at);
    int  i = 0;
    int  cyc = 0;
    bit  v;
    while (i < 176 && cyc < 2000) begin
      v = gaps ? ($urandom_range(3) != 0) : 1'b1;
      wr_valid  = v;
      wr_byte   = v ? mdl[i] : 8'($urandom);
      start_dec = v && (i == sd_at);
      chk("cap_wr_ready", 32'(wr_ready), 32'd1);
      chk("cap_keys_ready", 32'(keys_ready), 32'd0);
      tick();
      cyc++;
      if (start_dec) begin
        chk("sd_in_capture_rk_valid", 32'(rk_valid), 32'd0);
        chk("sd_in_capture_wr_ready", 32'(wr_ready), 32'd1);
      end
      if (v) i++;
    end
    wr_valid  = 1'b0;
    start_dec = 1'b0;
    chk("cap_count", 32'(i), 32'd176);
    chk("full_keys_ready", 32'(keys_ready), 32'd1);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    chk("full_rk_valid", 32'(rk_valid), 32'd0);
  endtask

  // Play back; mode 0 ready always, 1 ready toggling, 2 ready random with
  // stray start_dec pulses. Stops (without consuming) at transfer stop_at.
  task automatic play(input bit fwd_i, input int mode, input int stop_at);
    int         idx = 0;
    int         cyc = 0;
    int         er;
    int         eb;
    bit         rdy;
    bit         pstall = 1'b0;
    logic [7:0] pbyte = 8'h00;
    logic [3:0] pround = 4'h0;
    logic       plast = 1'b0;
    chk("pre_play_rk_valid", 32'(rk_valid), 32'd0);
    chk("pre_play_rk_byte", 32'(rk_byte), 32'd0);
`ifdef RKEY_FWD_PLAY_EN
    fwd = fwd_i;
`endif
    start_dec = 1'b1;
    rk_ready  = 1'b0;
    tick();
    start_dec = 1'b0;
    while (idx < 176 && cyc < 3000) begin
      er = fwd_i ? idx / 16 : 10 - idx / 16;
      eb = idx % 16;
      chk("play_rk_valid", 32'(rk_valid), 32'd1);
      chk("play_rk_byte", 32'(rk_byte), 32'(mdl[er*16 + eb]));
      chk("play_rk_round", 32'(rk_round), 32'(er));
      chk("play_rk_last", 32'(rk_last), 32'(eb == 15));
      if (pstall) begin
        chk("stall_hold_byte", 32'(rk_byte), 32'(pbyte));
        chk("stall_hold_round", 32'(rk_round), 32'(pround));
        chk("stall_hold_last", 32'(rk_last), 32'(plast));
      end
      if (idx == stop_at) break;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(1));
      endcase
      rk_ready  = rdy;
      start_dec = (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
      pstall = !rdy;
      pbyte  = rk_byte;
      pround = rk_round;
      plast  = rk_last;
      if (rdy) begin
        got[idx] = rk_byte;
        idx++;
      end
      tick();
      cyc++;
      start_dec = 1'b0;
    end
    if (stop_at < 0) begin
      rk_ready = 1'b0;
      chk("play_xfers", 32'(idx), 32'd176);
      chk("post_play_rk_valid", 32'(rk_valid), 32'd0);
      chk("post_play_rk_byte", 32'(rk_byte), 32'd0);
      chk("post_play_keys_ready", 32'(keys_ready), 32'd1);
      chk("post_play_wr_ready", 32'(wr_ready), 32'd0);
    end else begin
      chk("play_stop_reached", 32'(idx), 32'(stop_at));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_keys_ready"}, 32'(keys_ready), 32'd0);
    chk({tag, "_rk_valid"}, 32'(rk_valid), 32'd0);
    chk({tag, "_rk_byte"}, 32'(rk_byte), 32'd0);
    chk({tag, "_rk_round"}, 32'(rk_round), 32'd0);
    chk({tag, "_rk_last"}, 32'(rk_last), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    load      = 1'b0;
    wr_valid  = 1'b0;
    wr_byte   = 8'h00;
    start_dec = 1'b0;
    rk_ready  = 1'b0;
`ifdef RKEY_FWD_PLAY_EN
    fwd       = 1'b0;
`endif
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // FIPS-197 key, full-rate playback
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    capture(1'b0, -1);
    // wr_valid in FULL must neither write nor move the pointer
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_byte  = 8'($urandom);
      tick();
      chk("full_ignores_wr", 32'(wr_ready), 32'd0);
    end
    wr_valid = 1'b0;
    play(1'b0, 0, -1);
    chk("fips_first_byte", 32'(got[0]), 32'hd0);
    chk("fips_16th_byte", 32'(got[15]), 32'ha6);
    chk("fips_final_byte", 32'(got[175]), 32'h3c);

    // Replay with ready toggling every cycle
    play(1'b0, 1, -1);
    chk("replay_first_byte", 32'(got[0]), 32'hd0);
    chk("replay_final_byte", 32'(got[175]), 32'h3c);

`ifdef RKEY_FWD_PLAY_EN
    play(1'b1, 2, -1);
    chk("fwd_first_byte", 32'(got[0]), 32'h2b);
    chk("fwd_final_byte", 32'(got[175]), 32'ha6);
    play(1'b0, 2, -1);
`endif

    // Load during playback at byte 90, racing start_dec
    play(1'b0, 1, 90);
    load      = 1'b1;
    start_dec = 1'b1;
    rk_ready  = 1'b1;
    tick();
    load      = 1'b0;
    start_dec = 1'b0;
    rk_ready  = 1'b0;
    chk("load_abort_rk_valid", 32'(rk_valid), 32'd0);
    chk("load_abort_rk_byte", 32'(rk_byte), 32'd0);
    chk("load_abort_wr_ready", 32'(wr_ready), 32'd1);
    chk("load_abort_keys_ready", 32'(keys_ready), 32'd0);
    expand({$urandom, $urandom, $urandom, $urandom});
    capture(1'b1, -1);
    play(1'b0, 2, -1);

    // Load and start_dec together in FULL: load wins
    load      = 1'b1;
    start_dec = 1'b1;
    tick();
    load      = 1'b0;
    start_dec = 1'b0;
    chk("load_vs_sd_rk_valid", 32'(rk_valid), 32'd0);
    chk("load_vs_sd_wr_ready", 32'(wr_ready), 32'd1);

    // Partial capture, then load with a simultaneous (dropped) wr_valid
    expand({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1;
      wr_byte  = 8'($urandom);
      tick();
    end
    load     = 1'b1;
    wr_byte  = 8'($urandom);
    tick();
    load     = 1'b0;
    wr_valid = 1'b0;
    chk("load_restart_wr_ready", 32'(wr_ready), 32'd1);
    capture(1'b1, 40);
    play(1'b0, 2, -1);

    // Reset during playback in round 5, together with load
    play(1'b0, 0, 87);
    rst  = 1'b1;
    load = 1'b1;
    tick();
    rst      = 1'b0;
    load     = 1'b0;
    rk_ready = 1'b0;
    chk_reset_outputs("rst_in_play");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
